// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with parallel load, wrap/saturate bounds,
// a registered terminal-count pulse and a sticky overflow flag.
module param_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter bit SATURATE = 1'b0
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Enable,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             ClearOvf,
    output logic [WIDTH-1:0] CounterValue,
    output logic             TerminalCount,
    output logic             Overflow
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic             at_top;
    logic             at_bot;
    logic             event_hit;
    logic [WIDTH-1:0] step_value;
    logic [WIDTH-1:0] load_value;

    always_comb begin
        at_top     = (CounterValue == MAX_COUNT);
        at_bot     = (CounterValue == '0);
        event_hit  = Enable && !Load && (Up ? at_top : at_bot);
        load_value = (LoadValue > MAX_COUNT) ? MAX_COUNT : LoadValue;
        step_value = CounterValue;
        if (Up) begin
            if (at_top)
                step_value = SATURATE ? MAX_COUNT : '0;
            else
                step_value = CounterValue + 1'b1;
        end else begin
            if (at_bot)
                step_value = SATURATE ? '0 : MAX_COUNT;
            else
                step_value = CounterValue - 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            CounterValue  <= '0;
            TerminalCount <= 1'b0;
            Overflow      <= 1'b0;
        end else begin
            if (Load) begin
                CounterValue  <= load_value;
                TerminalCount <= 1'b0;
            end else if (Enable) begin
                CounterValue  <= step_value;
                TerminalCount <= event_hit;
            end else begin
                TerminalCount <= 1'b0;
            end
            // A boundary event outranks a same-cycle clear request.
            if (event_hit)
                Overflow <= 1'b1;
            else if (ClearOvf)
                Overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: three instances (mod-256 wrap, mod-10 wrap,
// mod-10 saturate) driven together and checked against a reference model.
module tb_param_updown_counter;

    typedef struct {
        logic [7:0] v;
        logic       tc;
        logic       ovf;
    } st_t;

    typedef struct {
        st_t a;
        st_t b;
        st_t c;
    } exp_t;

    typedef struct {
        logic       rstn;
        logic       ld;
        logic       en;
        logic       up;
        logic       clr;
        logic [7:0] lv;
        logic [3:0] bv;
        logic       btc;
        logic       bovf;
        logic [3:0] cv;
        logic       ctc;
        logic       covf;
    } vec_t;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       up;
    logic       ld;
    logic       clr;
    logic [7:0] lv;

    logic [7:0] a_val;
    logic       a_tc;
    logic       a_ovf;
    logic [3:0] b_val;
    logic       b_tc;
    logic       b_ovf;
    logic [3:0] c_val;
    logic       c_tc;
    logic       c_ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    st_t  ma;
    st_t  mb;
    st_t  mc;
    exp_t q[$];
    vec_t tbl[$];

    param_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0)) dut_a (
        .Clock(clk), .Resetn(rstn), .Enable(en), .Up(up), .Load(ld),
        .LoadValue(lv), .ClearOvf(clr),
        .CounterValue(a_val), .TerminalCount(a_tc), .Overflow(a_ovf)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_b (
        .Clock(clk), .Resetn(rstn), .Enable(en), .Up(up), .Load(ld),
        .LoadValue(lv[3:0]), .ClearOvf(clr),
        .CounterValue(b_val), .TerminalCount(b_tc), .Overflow(b_ovf)
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_c (
        .Clock(clk), .Resetn(rstn), .Enable(en), .Up(up), .Load(ld),
        .LoadValue(lv[3:0]), .ClearOvf(clr),
        .CounterValue(c_val), .TerminalCount(c_tc), .Overflow(c_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic st_t nxt(st_t s, logic r, logic l, logic e,
                                logic u, logic c, logic [7:0] v,
                                int modulus, bit sat);
        st_t n;
        bit  hit;
        n   = s;
        hit = 1'b0;
        if (!r) begin
            n.v   = '0;
            n.tc  = 1'b0;
            n.ovf = 1'b0;
            return n;
        end
        if (l) begin
            n.v = (int'(v) > modulus - 1) ? 8'(modulus - 1) : v;
        end else if (e) begin
            if (u) begin
                if (int'(s.v) == modulus - 1) begin
                    hit = 1'b1;
                    n.v = sat ? s.v : 8'd0;
                end else begin
                    n.v = s.v + 8'd1;
                end
            end else begin
                if (s.v == 8'd0) begin
                    hit = 1'b1;
                    n.v = sat ? 8'd0 : 8'(modulus - 1);
                end else begin
                    n.v = s.v - 8'd1;
                end
            end
        end
        n.tc = hit;
        if (hit)
            n.ovf = 1'b1;
        else if (c)
            n.ovf = 1'b0;
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic l, input logic e,
                       input logic u, input logic c, input logic [7:0] v);
        exp_t x;
        rstn = r;
        ld   = l;
        en   = e;
        up   = u;
        clr  = c;
        lv   = v;
        ma = nxt(ma, r, l, e, u, c, v, 256, 1'b0);
        mb = nxt(mb, r, l, e, u, c, {4'h0, v[3:0]}, 10, 1'b0);
        mc = nxt(mc, r, l, e, u, c, {4'h0, v[3:0]}, 10, 1'b1);
        q.push_back('{ma, mb, mc});
        @(posedge clk);
        #1;
        x = q.pop_front();
        chk("a_val", int'(a_val), int'(x.a.v));
        chk("a_tc",  int'(a_tc),  int'(x.a.tc));
        chk("a_ovf", int'(a_ovf), int'(x.a.ovf));
        chk("b_val", int'(b_val), int'(x.b.v));
        chk("b_tc",  int'(b_tc),  int'(x.b.tc));
        chk("b_ovf", int'(b_ovf), int'(x.b.ovf));
        chk("c_val", int'(c_val), int'(x.c.v));
        chk("c_tc",  int'(c_tc),  int'(x.c.tc));
        chk("c_ovf", int'(c_ovf), int'(x.c.ovf));
    endtask

    initial begin
        logic [7:0] held;
        ma = '{8'd0, 1'b0, 1'b0};
        mb = '{8'd0, 1'b0, 1'b0};
        mc = '{8'd0, 1'b0, 1'b0};
        rstn = 1'b0;
        en   = 1'b0;
        up   = 1'b0;
        ld   = 1'b0;
        clr  = 1'b0;
        lv   = 8'd0;

        // rstn ld en up clr lv | B val tc ovf | C val tc ovf
        tbl.push_back('{0, 0, 0, 0, 0, 8'd0,  4'd0, 0, 0, 4'd0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 8'd9,  4'd9, 0, 0, 4'd9, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 8'd0,  4'd0, 1, 1, 4'd9, 1, 1});
        tbl.push_back('{1, 0, 1, 0, 0, 8'd0,  4'd9, 1, 1, 4'd8, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 8'd13, 4'd9, 0, 1, 4'd9, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 8'd8,  4'd8, 0, 1, 4'd8, 0, 1});
        tbl.push_back('{1, 0, 1, 1, 0, 8'd0,  4'd9, 0, 1, 4'd9, 0, 1});
        tbl.push_back('{1, 0, 1, 1, 0, 8'd0,  4'd0, 1, 1, 4'd9, 1, 1});
        tbl.push_back('{1, 0, 1, 1, 0, 8'd0,  4'd1, 0, 1, 4'd9, 1, 1});
        tbl.push_back('{1, 0, 1, 1, 0, 8'd0,  4'd2, 0, 1, 4'd9, 1, 1});
        tbl.push_back('{1, 0, 0, 0, 1, 8'd0,  4'd2, 0, 0, 4'd9, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 8'd0,  4'd0, 0, 0, 4'd0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 8'd0,  4'd9, 1, 1, 4'd0, 1, 1});
        tbl.push_back('{1, 1, 1, 1, 0, 8'd5,  4'd5, 0, 1, 4'd5, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 1, 8'd0,  4'd5, 0, 0, 4'd5, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 8'd9,  4'd9, 0, 0, 4'd9, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 1, 8'd0,  4'd0, 1, 1, 4'd9, 1, 1});
        tbl.push_back('{1, 0, 0, 1, 1, 8'd0,  4'd0, 0, 0, 4'd9, 0, 0});

        // Full 8-bit wrap sweep
        cyc(0, 0, 0, 0, 0, 8'd0);
        for (int k = 1; k <= 256; k++) begin
            cyc(1, 0, 1, 1, 0, 8'd0);
            if (k == 255) begin
                chk("sweep_255_val", int'(a_val), 255);
                chk("sweep_255_tc", int'(a_tc), 0);
                chk("sweep_255_ovf", int'(a_ovf), 0);
            end
        end
        chk("sweep_wrap_val", int'(a_val), 0);
        chk("sweep_wrap_tc", int'(a_tc), 1);
        chk("sweep_wrap_ovf", int'(a_ovf), 1);

        // Mod-10 wrap/saturate, load clamp and priority vectors
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rstn, tbl[i].ld, tbl[i].en, tbl[i].up,
                tbl[i].clr, tbl[i].lv);
            chk($sformatf("tbl%0d_b_val", i), int'(b_val), int'(tbl[i].bv));
            chk($sformatf("tbl%0d_b_tc", i), int'(b_tc), int'(tbl[i].btc));
            chk($sformatf("tbl%0d_b_ovf", i), int'(b_ovf), int'(tbl[i].bovf));
            chk($sformatf("tbl%0d_c_val", i), int'(c_val), int'(tbl[i].cv));
            chk($sformatf("tbl%0d_c_tc", i), int'(c_tc), int'(tbl[i].ctc));
            chk($sformatf("tbl%0d_c_ovf", i), int'(c_ovf), int'(tbl[i].covf));
        end

        // Reset in the middle of counting, with load and enable asserted
        cyc(0, 0, 0, 0, 0, 8'd0);
        for (int k = 0; k < 8'h37; k++)
            cyc(1, 0, 1, 1, 0, 8'd0);
        chk("mid_count_val", int'(a_val), 8'h37);
        cyc(0, 1, 1, 1, 0, 8'hAA);
        chk("mid_rst_val", int'(a_val), 0);
        chk("mid_rst_tc", int'(a_tc), 0);
        chk("mid_rst_ovf", int'(a_ovf), 0);
        cyc(1, 0, 1, 1, 0, 8'd0);
        chk("resume_val", int'(a_val), 1);

        // Idle with Up toggling randomly: value must hold, no pulses
        held = 8'd1;
        for (int k = 0; k < 20; k++) begin
            cyc(1, 0, 0, 1'($urandom_range(0, 1)), 0, 8'($urandom_range(0, 255)));
            chk("idle_val", int'(a_val), int'(held));
            chk("idle_tc", int'(a_tc), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
